// File: rtl/pbkdf2_block.sv
// PBKDF2 single-block sequencer around an external HMAC core.
// Chains U1..Uc through the core and XOR-accumulates them into dk.
module pbkdf2_block #(
  parameter int ITER_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1023:0]     key,
  input  logic [255:0]      salt,
  input  logic [31:0]       blk_idx,
  input  logic [ITER_W-1:0] iters,
  output logic              busy,
  output logic              done,
  output logic [511:0]      dk,
  output logic              hmac_rst_n,
  output logic              hmac_mode,
  output logic [1023:0]     hmac_key,
  output logic [511:0]      hmac_msg,
  input  logic              hmac_done,
  input  logic [511:0]      hmac_out
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ACCUM,
    FIN
  } state_t;

  state_t              state, state_n;
  logic [ITER_W-1:0]   iters_q, iters_n;
  logic [ITER_W-1:0]   count, count_n;
  logic [511:0]        acc, acc_n;
  logic [511:0]        u, u_n;
  logic [511:0]        dk_n;
  logic [511:0]        msg_n;
  logic [1023:0]       key_n;
  logic                busy_n, done_n, rst_n_n, mode_n;

  always_comb begin
    state_n = state;
    iters_n = iters_q;
    count_n = count;
    acc_n   = acc;
    u_n     = u;
    dk_n    = dk;
    msg_n   = hmac_msg;
    key_n   = hmac_key;
    busy_n  = busy;
    done_n  = 1'b0;
    rst_n_n = hmac_rst_n;
    mode_n  = hmac_mode;
    unique case (state)
      IDLE: begin
        rst_n_n = 1'b0;
        if (start) begin
          key_n   = key;
          iters_n = (iters == '0) ? ITER_W'(1) : iters;
          acc_n   = '0;
          count_n = ITER_W'(1);
          mode_n  = 1'b0;
          msg_n   = {salt, blk_idx, 224'b0};
          busy_n  = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        // a done level still high from the previous run is ignored here
        rst_n_n = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (hmac_done) begin
          u_n     = hmac_out;
          acc_n   = acc ^ hmac_out;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        rst_n_n = 1'b0;
        if (count == iters_q) begin
          state_n = FIN;
        end else begin
          count_n = count + ITER_W'(1);
          mode_n  = 1'b1;
          msg_n   = u;
          state_n = LAUNCH;
        end
      end
      FIN: begin
        rst_n_n = 1'b0;
        dk_n    = acc;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        rst_n_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      iters_q    <= '0;
      count      <= '0;
      acc        <= '0;
      u          <= '0;
      dk         <= '0;
      hmac_msg   <= '0;
      hmac_key   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hmac_rst_n <= 1'b0;
      hmac_mode  <= 1'b0;
    end else begin
      state      <= state_n;
      iters_q    <= iters_n;
      count      <= count_n;
      acc        <= acc_n;
      u          <= u_n;
      dk         <= dk_n;
      hmac_msg   <= msg_n;
      hmac_key   <= key_n;
      busy       <= busy_n;
      done       <= done_n;
      hmac_rst_n <= rst_n_n;
      hmac_mode  <= mode_n;
    end
  end

endmodule

// File: tb/tb_pbkdf2_block.sv
// Directed bench for pbkdf2_block with a fixed-latency HMAC stub.
// The stub returns a programmed response per launch after 10 cycles.
module tb_pbkdf2_block;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1023:0] key;
  logic [255:0]  salt;
  logic [31:0]   blk_idx;
  logic [W-1:0]  iters;
  logic          busy, done;
  logic [511:0]  dk;
  logic          hmac_rst_n, hmac_mode;
  logic [1023:0] hmac_key;
  logic [511:0]  hmac_msg;
  logic          hmac_done;
  logic [511:0]  hmac_out;

  pbkdf2_block #(.ITER_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .salt       (salt),
    .blk_idx    (blk_idx),
    .iters      (iters),
    .busy       (busy),
    .done       (done),
    .dk         (dk),
    .hmac_rst_n (hmac_rst_n),
    .hmac_mode  (hmac_mode),
    .hmac_key   (hmac_key),
    .hmac_msg   (hmac_msg),
    .hmac_done  (hmac_done),
    .hmac_out   (hmac_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int launches = 0;
  int dones = 0;
  int base_l = 0;
  int base_d = 0;
  int scnt = 0;
  logic prev_rn = 1'b0;
  logic [511:0] resp [0:3];
  logic         mode_log [0:7];
  logic [511:0] msg_log [0:7];

  always @(posedge clk) begin
    prev_rn <= hmac_rst_n;
    if (done) dones <= dones + 1;
    if (hmac_rst_n && !prev_rn) begin
      mode_log[(launches - base_l) & 7] <= hmac_mode;
      msg_log[(launches - base_l) & 7]  <= hmac_msg;
      launches <= launches + 1;
    end
  end

  always @(posedge clk or negedge hmac_rst_n) begin
    if (!hmac_rst_n) begin
      scnt      <= 0;
      hmac_done <= 1'b0;
      hmac_out  <= '0;
    end else if (scnt < 10) begin
      scnt <= scnt + 1;
      if (scnt == 9) begin
        hmac_done <= 1'b1;
        hmac_out  <= resp[(launches - base_l - 1) & 3];
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] o,
                     input logic [511:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic do_op(input logic [255:0] s, input logic [31:0] b,
                       input logic [W-1:0] it, input int poke,
                       output int lat);
    base_l = launches;
    base_d = dones;
    @(negedge clk);
    salt = s; blk_idx = b; iters = it; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; salt = ~s; blk_idx = ~b; iters = it + 5;
    while (!done && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (lat == poke);
      if (lat == 5) chk("busy_mid", 512'(busy), 512'(1));
    end
    start = 1'b0;
    chk("done_seen", 512'(done), 512'(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [255:0] s1, s2;
  logic [511:0] a, b, c, d, e;
  logic [511:0] exp_msg;
  int lat;
  int guard;

  initial begin
    s1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    s2 = 256'hdeadbeef00000000111111112222222233333333444444445555555566666666;
    a  = {8{64'h0123456789abcdef}};
    b  = {16{32'hf0e1d2c3}};
    c  = {16{32'h13579bdf}};
    d  = {8{64'h5a5a5a5a00ff00ff}};
    e  = {8{64'h1122334455667788}};
    key = {64'h70617373776f7264, 960'b0};
    reset = 1'b1; start = 1'b0; salt = '0; blk_idx = '0; iters = '0;
    resp[0] = a; resp[1] = b; resp[2] = c; resp[3] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_dk", dk, '0);
    chk("rst_hrn", 512'(hmac_rst_n), 512'(0));
    chk("rst_mode", 512'(hmac_mode), 512'(0));
    chk("rst_msg", hmac_msg, '0);
    reset = 1'b0;
    @(negedge clk);

    exp_msg = {s1, 32'd1, 224'b0};
    do_op(s1, 32'd1, 1, 0, lat);
    chk("i1_lat", 512'(lat), 512'(15));
    chk("i1_launch", 512'(launches - base_l), 512'(1));
    chk("i1_mode", 512'(mode_log[0]), 512'(0));
    chk("i1_msg", msg_log[0], exp_msg);
    chk("i1_key", hmac_key, key);
    chk("i1_dk", dk, a);
    chk("i1_ndone", 512'(dones - base_d), 512'(1));
    chk("i1_hrn_idle", 512'(hmac_rst_n), 512'(0));
    repeat (5) @(negedge clk);
    chk("dk_hold", dk, a);

    do_op(s1, 32'd1, 3, 0, lat);
    chk("i3_lat", 512'(lat), 512'(41));
    chk("i3_launch", 512'(launches - base_l), 512'(3));
    chk("i3_mode1", 512'(mode_log[0]), 512'(0));
    chk("i3_mode2", 512'(mode_log[1]), 512'(1));
    chk("i3_msg2", msg_log[1], a);
    chk("i3_mode3", 512'(mode_log[2]), 512'(1));
    chk("i3_msg3", msg_log[2], b);
    chk("i3_dk", dk, a ^ b ^ c);

    do_op(s1, 32'd7, 0, 0, lat);
    chk("i0_launch", 512'(launches - base_l), 512'(1));
    chk("i0_lat", 512'(lat), 512'(15));
    chk("i0_dk", dk, a);

    do_op(s1, 32'd1, 1, 6, lat);
    chk("poke_launch", 512'(launches - base_l), 512'(1));
    chk("poke_msg", msg_log[0], exp_msg);
    chk("poke_dk", dk, a);
    repeat (20) @(negedge clk);
    chk("poke_nodone", 512'(dones - base_d), 512'(1));
    chk("poke_idle", 512'(busy), 512'(0));

    base_l = launches;
    base_d = dones;
    @(negedge clk);
    salt = s1; blk_idx = 32'd1; iters = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while ((launches - base_l) < 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reach_it2", 512'(launches - base_l), 512'(2));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_busy", 512'(busy), 512'(0));
    chk("ar_done", 512'(done), 512'(0));
    chk("ar_dk", dk, '0);
    chk("ar_hrn", 512'(hmac_rst_n), 512'(0));
    chk("ar_mode", 512'(hmac_mode), 512'(0));
    chk("ar_msg", hmac_msg, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("ar_nodone", 512'(dones - base_d), 512'(0));

    resp[0] = d; resp[1] = e;
    do_op(s2, 32'd2, 2, 0, lat);
    chk("re_launch", 512'(launches - base_l), 512'(2));
    chk("re_mode1", 512'(mode_log[0]), 512'(0));
    chk("re_msg1", msg_log[0], {s2, 32'd2, 224'b0});
    chk("re_msg2", msg_log[1], d);
    chk("re_dk", dk, d ^ e);
    chk("re_lat", 512'(lat), 512'(28));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pbkdf2_block.md
PBKDF2_BLOCK -- requirements
Module: pbkdf2_block

Interface
REQ-001 SHALL have parameter ITER_W, default 32, iteration-count width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to compute one PBKDF2 block; sampled only in IDLE.
REQ-005 SHALL have port key  input  1024  HMAC key (password), already zero-padded; passed to hmac_key unchanged.
REQ-006 SHALL have port salt  input  256  32-byte salt, byte 0 in bits [255:248].
REQ-007 SHALL have port blk_idx  input  32  PBKDF2 block index i, big-endian.
REQ-008 SHALL have port iters  input  ITER_W  iteration count c.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse; dk valid.
REQ-011 SHALL have port dk  output  512  derived block T_i = U1^...^Uc.
REQ-012 SHALL have ports hmac_rst_n  output  1 (active-low reset to hmac core), hmac_mode  output  1, hmac_key  output  1024, hmac_msg  output  512, hmac_done  input  1 (level), hmac_out  input  512.

Function
REQ-013 SHALL implement states IDLE, LAUNCH, WAIT, ACCUM, FIN; all outputs registered.
REQ-014 IDLE with start=1 SHALL latch key, salt, blk_idx, iters (0 treated as 1), clear acc to 0, set count=1, drive hmac_mode=0, hmac_msg={salt, blk_idx, 224'b0}, and go to LAUNCH.
REQ-015 LAUNCH SHALL hold hmac_rst_n=0 for exactly one cycle, then go to WAIT with hmac_rst_n=1.
REQ-016 WAIT SHALL remain until hmac_done=1; hmac latency unbounded, no timeout.
REQ-017 On leaving WAIT, the block SHALL register u=hmac_out and acc=acc^hmac_out (ACCUM, one cycle).
REQ-018 ACCUM with count==latched iters SHALL go to FIN; otherwise it SHALL increment count, set hmac_mode=1, hmac_msg=u, and go to LAUNCH.
REQ-019 FIN SHALL load dk=acc, pulse done for one cycle, drop busy, and return to IDLE; dk SHALL hold until the next FIN.
REQ-020 Per-iteration overhead outside hmac SHALL be exactly 3 cycles (LAUNCH, ACCUM, the WAIT exit cycle); start-to-done = 2 + sum of per-iteration cycles.
REQ-021 start while not IDLE SHALL be ignored; input changes after acceptance SHALL have no effect.
REQ-022 hmac_done=1 seen in LAUNCH SHALL be ignored (stale).
REQ-023 count SHALL be ITER_W bits and never wrap: max iters 2^ITER_W-1 completes normally.
REQ-024 hmac_rst_n SHALL stay low in IDLE and FIN, holding the core idle.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE, busy=0, done=0, dk=0, acc=0, count=0, hmac_rst_n=0, hmac_mode=0, hmac_msg=0.
REQ-026 reset mid-operation SHALL abort; no done pulse; next start restarts from U1.

Verification
REQ-027 Stub hmac (latency 10, returns A): iters=1 -> exactly one launch, hmac_mode=0, hmac_msg[511:224]={salt,blk_idx}, hmac_msg[223:0]=0, done once, dk=A, start-to-done = 15 cycles.
REQ-028 Stub returns A,B,C, iters=3 -> launches 2 and 3 show mode=1 with msg=A then B; dk=A^B^C.
REQ-029 iters=0 -> behaves as iters=1: exactly one hmac_rst_n low pulse.
REQ-030 start pulsed during WAIT with different salt -> ignored; dk matches the original salt.
REQ-031 reset asserted in WAIT of iteration 2 -> all outputs zero same cycle, no done; new start with iters=2 yields correct dk.
REQ-032 With the real hmac core: key="password" zero-padded, salt=32 bytes 0x00..0x1f, blk_idx=1, iters=1, 2, 1000 -> dk equals software PBKDF2-HMAC-SHA512 block 1.
